tdc_therm2bin_err: RTL and testbench
====================================

Name: tdc_therm2bin_err

Overview:
- Downstream consumer of the 5-bit sequential-PD TDC.
- Samples the 32-bit thermometer-coded up/down error words, converts each to a binary count, and forms a signed phase error (up − dwn).
- Flags bubbles and saturation, hands the error to the digital loop filter over a valid/ready handshake, and maintains a lock indicator.
- Runs in the feedback-clock domain.

Parameters:
- WIDTH, 32, thermometer code width.
- CNT_W, 6, binary count width (0..WIDTH).
- ERR_W, 7, signed error width (−WIDTH..+WIDTH).
- LOCK_TOL, 1, max |error| counted as in-lock.
- LOCK_CNT, 16, consecutive in-tolerance results required to assert locked.

Ports:
- fb_clk  in  1  clock; all state updates on rising edge.
- reset_trig  in  1  reset, asynchronous, active-high.
- en  in  1  sample enable; a capture occurs only on edges with en=1.
- up_therm  in  WIDTH  UP thermometer code (ones fill from bit 0 upward).
- dwn_therm  in  WIDTH  DWN thermometer code.
- err_out  out  ERR_W  signed phase error, two's complement, up_cnt − dwn_cnt.
- err_valid  out  1  err_out holds an unconsumed result.
- err_ready  in  1  loop filter accepts err_out.
- sat_up  out  1  up_cnt == WIDTH for the result on err_out.
- sat_dn  out  1  dwn_cnt == WIDTH for the result on err_out.
- bubble_err  out  1  sticky; either code was not of form 2^k−1.
- overrun  out  1  sticky; a result was dropped because the output was held.
- locked  out  1  lock indicator.

Behaviour:
- Reset: all outputs 0, all pipeline valids 0, lock counter 0. Reset is honoured mid-pipeline and discards any in-flight result.
- Pipeline stage S0 (capture): when en=1, register up_therm/dwn_therm and set v0=1. When en=0, set v0=0.
- Pipeline stage S1 (decode):
  - up_cnt = popcount(up_q) and dwn_cnt = popcount(dwn_q), each CNT_W bits unsigned.
  - bubble check: a code is illegal if any 0 bit has a 1 at a higher index. Set bubble_err on an illegal code; it stays set until reset.
  - Counts are popcounts regardless of bubbles. Bubble correction is a report only.
- Pipeline stage S2 (output register):
  - err = zero-extended up_cnt − zero-extended dwn_cnt, computed in ERR_W bits.
  - Range is −32..+32, so overflow is impossible.
  - sat_up and sat_dn are registered alongside err.
- Latency: inputs captured at edge N appear on err_out with err_valid=1 after edge N+2 when the output is free. Throughput is one result per fb_clk.
- Handshake:
  - Transfer occurs on an edge where err_valid && err_ready.
  - While err_valid && !err_ready: err_out, sat_up and sat_dn are held stable.
  - An S1 result arriving while the output is held is dropped and overrun is set (sticky).
  - A held result is never overwritten.
  - When err_valid=0, or a transfer occurs on the same edge, a new S1 result loads into S2 and err_valid=1.
  - With no new S1 result, err_valid drops to 0 after the transfer.
- Lock (updated per transfer only):
  - If |err_out| ≤ LOCK_TOL, increment the counter, saturating at LOCK_CNT. Otherwise clear both the counter and locked.
  - locked is set on the edge the counter reaches LOCK_CNT.
  - A saturated result (sat_up or sat_dn) always counts as out-of-tolerance.
- Simultaneous events: reset_trig dominates everything. Transfer and load on the same edge is legal and loses no data.

Decomposition:
- Shared package tdc_pkg holds:
  - WIDTH, CNT_W, ERR_W constants.
  - A typedef for the signed error word.
  - A typedef for the count.
  - The lock-state enum {UNLOCKED, ACQUIRING, LOCKED}, used for the counter-driven lock FSM.
- One sub-module: therm_decode (WIDTH-bit popcount plus bubble detect), instantiated twice, for up and dwn.

Test Plan:
- Reset, then en=1, up_therm=0x0000_00FF, dwn_therm=0x0000_0007, err_ready=1 → after 2 edges err_out=+5, err_valid=1, sat flags 0, bubble_err 0.
- up=0x0000_0001, dwn=0xFFFF_FFFF → err_out=−31 (0x61 in 7 bits), sat_dn=1; next sample up=0xFFFF_FFFF, dwn=0 → err_out=+32, sat_up=1.
- Hold err_ready=0 for 3 edges with a continuous stream of samples → err_out stays equal to the first result, overrun=1; raise err_ready → first result transfers, pipeline resumes.
- up=0x0000_00F7 (bubble), dwn=0 → bubble_err=1 and err_out=+7; bubble_err persists across later clean samples until reset_trig.
- 16 consecutive transfers with err_out=+1/−1 → locked rises on the 16th; a single err_out=+4 → locked=0, counter cleared.
- Assert reset_trig asynchronously with a result in S1 and one held at the output → all outputs 0 immediately; after release the first output appears only 2 edges after a new en=1 capture.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC thermometer-to-binary error path.
package tdc_pkg;

    localparam int TDC_WIDTH = 32;
    localparam int TDC_CNT_W = 6;
    localparam int TDC_ERR_W = 7;

    typedef logic signed [TDC_ERR_W-1:0] err_t;
    typedef logic [TDC_CNT_W-1:0]        cnt_t;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRING,
        LOCKED
    } lock_state_e;

endpackage

// File: rtl/therm_decode.sv
// Thermometer word to popcount, plus a flag for codes not of the form 2^k-1.
module therm_decode
    import tdc_pkg::*;
#(
    parameter int WIDTH = TDC_WIDTH,
    parameter int CNT_W = TDC_CNT_W
) (
    input  logic [WIDTH-1:0] code,
    output logic [CNT_W-1:0] cnt,
    output logic             bubble
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            cnt = cnt + CNT_W'(code[i]);
    end

    // 2^k-1 shares no set bit with its own increment; any overlap means a hole
    assign bubble = |(code & (code + WIDTH'(1)));

endmodule

// File: rtl/tdc_therm2bin_err.sv
// Capture -> decode -> output-register pipeline turning up/dwn thermometer words
// into a signed phase error with valid/ready hand-off and a lock tracker.
module tdc_therm2bin_err
    import tdc_pkg::*;
#(
    parameter int WIDTH    = TDC_WIDTH,
    parameter int CNT_W    = TDC_CNT_W,
    parameter int ERR_W    = TDC_ERR_W,
    parameter int LOCK_TOL = 1,
    parameter int LOCK_CNT = 16
) (
    input  logic             fb_clk,
    input  logic             reset_trig,
    input  logic             en,
    input  logic [WIDTH-1:0] up_therm,
    input  logic [WIDTH-1:0] dwn_therm,
    output logic [ERR_W-1:0] err_out,
    output logic             err_valid,
    input  logic             err_ready,
    output logic             sat_up,
    output logic             sat_dn,
    output logic             bubble_err,
    output logic             overrun,
    output logic             locked
);

    localparam int NUM_LANES = 2;   // lane 0 = up, lane 1 = dwn
    localparam int STAGES    = 1;
    localparam int LCNT_W    = $clog2(LOCK_CNT + 1);
    localparam logic signed [ERR_W-1:0] TOL = ERR_W'(LOCK_TOL);

    logic [STAGES:0]                 vld_pipe;
    logic [NUM_LANES-1:0][WIDTH-1:0] code_q;
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_LANES-1:0]            bub_d;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        therm_decode #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dec (
            .code   (code_q[l]),
            .cnt    (cnt_d[l]),
            .bubble (bub_d[l])
        );
    end

    always_ff @(posedge fb_clk or posedge reset_trig) begin
        if (reset_trig) begin
            vld_pipe   <= '0;
            code_q     <= '0;
            cnt_q      <= '0;
            bubble_err <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], en};
            if (en)
                code_q <= {dwn_therm, up_therm};
            if (vld_pipe[0]) begin
                cnt_q <= cnt_d;
                if (|bub_d)
                    bubble_err <= 1'b1;
            end
        end
    end

    logic xfer;
    logic held;
    assign xfer = err_valid && err_ready;
    assign held = err_valid && !err_ready;

    // A held result is never replaced; a decode arriving behind it is lost.
    always_ff @(posedge fb_clk or posedge reset_trig) begin
        if (reset_trig) begin
            err_out   <= '0;
            err_valid <= 1'b0;
            sat_up    <= 1'b0;
            sat_dn    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (vld_pipe[STAGES] && !held) begin
                err_out   <= ERR_W'(cnt_q[0]) - ERR_W'(cnt_q[1]);
                sat_up    <= (cnt_q[0] == CNT_W'(WIDTH));
                sat_dn    <= (cnt_q[1] == CNT_W'(WIDTH));
                err_valid <= 1'b1;
            end else if (xfer) begin
                err_valid <= 1'b0;
            end
            if (vld_pipe[STAGES] && held)
                overrun <= 1'b1;
        end
    end

    lock_state_e       state, state_n;
    logic [LCNT_W-1:0] lock_cnt, lock_cnt_n;
    logic              in_tol;

    assign in_tol = !sat_up && !sat_dn &&
                    ($signed(err_out) <= TOL) && ($signed(err_out) >= -TOL);

    always_ff @(posedge fb_clk or posedge reset_trig) begin
        if (reset_trig) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        lock_cnt_n = lock_cnt;
        if (xfer) begin
            if (in_tol) begin
                if (lock_cnt != LCNT_W'(LOCK_CNT))
                    lock_cnt_n = lock_cnt + LCNT_W'(1);
                state_n = (lock_cnt_n == LCNT_W'(LOCK_CNT)) ? LOCKED : ACQUIRING;
            end else begin
                lock_cnt_n = '0;
                state_n    = UNLOCKED;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdc_therm2bin_err.sv
// Bench for tdc_therm2bin_err: fixed vectors, hand sequences and a random run
// checked against a latency/handshake model built from popcounts.
module tb_tdc_therm2bin_err;
    import tdc_pkg::*;

    logic        fb_clk = 1'b0;
    logic        reset_trig = 1'b1;
    logic        en = 1'b0;
    logic        err_ready = 1'b0;
    logic [31:0] up_therm = '0;
    logic [31:0] dwn_therm = '0;
    logic [6:0]  err_out;
    logic        err_valid, sat_up, sat_dn, bubble_err, overrun, locked;

    always #5 fb_clk = ~fb_clk;

    tdc_therm2bin_err dut (
        .fb_clk     (fb_clk),
        .reset_trig (reset_trig),
        .en         (en),
        .up_therm   (up_therm),
        .dwn_therm  (dwn_therm),
        .err_out    (err_out),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .sat_up     (sat_up),
        .sat_dn     (sat_dn),
        .bubble_err (bubble_err),
        .overrun    (overrun),
        .locked     (locked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: each sample's result is computed at capture and then
    // travels a two-edge delay line before meeting the output handshake.
    typedef struct { int err; bit su; bit sd; bit bub; } res_t;
    res_t d0, d1;
    bit   d0_v, d1_v;
    bit   m_valid, m_ovr, m_bub, m_locked, m_su, m_sd;
    int   m_err, m_lcnt;

    function automatic bit legal(logic [31:0] c);
        bit seen0 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!c[i]) seen0 = 1'b1;
            else if (seen0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic res_t evaluate(logic [31:0] u, logic [31:0] d);
        res_t r;
        int cu = $countones(u);
        int cd = $countones(d);
        r.err = cu - cd;
        r.su  = (cu == 32);
        r.sd  = (cd == 32);
        r.bub = !legal(u) || !legal(d);
        return r;
    endfunction

    function automatic logic [31:0] therm(int k);
        if (k <= 0) return 32'h0;
        if (k >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << k) - 32'h1;
    endfunction

    task automatic model_reset();
        d0_v = 0; d1_v = 0; m_valid = 0; m_ovr = 0; m_bub = 0; m_locked = 0;
        m_su = 0; m_sd = 0; m_err = 0; m_lcnt = 0;
    endtask

    task automatic model_edge();
        bit xfer = m_valid && err_ready;
        bit hold = m_valid && !err_ready;
        if (xfer) begin
            if (!m_su && !m_sd && m_err >= -1 && m_err <= 1) begin
                if (m_lcnt < 16) m_lcnt++;
                if (m_lcnt == 16) m_locked = 1;
            end else begin
                m_lcnt = 0;
                m_locked = 0;
            end
        end
        if (d1_v && hold) m_ovr = 1;
        else if (d1_v) begin
            m_valid = 1; m_err = d1.err; m_su = d1.su; m_sd = d1.sd;
        end else if (xfer) m_valid = 0;
        if (d0_v && d0.bub) m_bub = 1;
        d1 = d0; d1_v = d0_v;
        d0 = evaluate(up_therm, dwn_therm); d0_v = en;
    endtask

    task automatic check_model();
        chk("valid", int'(err_valid), int'(m_valid));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("bubble", int'(bubble_err), int'(m_bub));
        chk("locked", int'(locked), int'(m_locked));
        if (m_valid) begin
            chk("err", int'($signed(err_out)), m_err);
            chk("sat_up", int'(sat_up), int'(m_su));
            chk("sat_dn", int'(sat_dn), int'(m_sd));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge fb_clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset_trig = 1'b1;
        model_reset();
        #3;
        reset_trig = 1'b0;
    endtask

    typedef struct { logic [31:0] up; logic [31:0] dn; int err; bit su; bit sd; bit bub; } vec_t;
    vec_t tv[7];

    initial begin
        tv[0] = '{32'h0000_00FF, 32'h0000_0007,   5, 0, 0, 0};
        tv[1] = '{32'h0000_0001, 32'hFFFF_FFFF, -31, 0, 1, 0};
        tv[2] = '{32'hFFFF_FFFF, 32'h0000_0000,  32, 1, 0, 0};
        tv[3] = '{32'h0000_0000, 32'h0000_0000,   0, 0, 0, 0};
        tv[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,   0, 1, 1, 0};
        tv[5] = '{32'h0000_00F7, 32'h0000_0000,   7, 0, 0, 1};
        tv[6] = '{32'h0000_FFFF, 32'h0000_0000,  16, 0, 0, 1};

        model_reset();
        #2;
        chk("rst_err", int'(err_out), 0);
        chk("rst_valid", int'(err_valid), 0);
        chk("rst_flags", int'({sat_up, sat_dn, bubble_err, overrun, locked}), 0);
        reset_trig = 1'b0;

        // single samples, one at a time, each read after its two-edge latency
        err_ready = 1'b1;
        foreach (tv[i]) begin
            up_therm = tv[i].up; dwn_therm = tv[i].dn; en = 1'b1;
            step();
            en = 1'b0;
            step();
            step();
            chk("tv_valid", int'(err_valid), 1);
            chk("tv_err", int'($signed(err_out)), tv[i].err);
            chk("tv_sat_up", int'(sat_up), int'(tv[i].su));
            chk("tv_sat_dn", int'(sat_dn), int'(tv[i].sd));
            chk("tv_bubble", int'(bubble_err), int'(tv[i].bub));
        end
        step();

        // stall: sample k captured at edge k carries err=+k
        do_reset();
        err_ready = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            up_therm = therm(k); dwn_therm = '0;
            if (k == 4) err_ready = 1'b0;
            if (k == 7) err_ready = 1'b1;
            step();
            if (k >= 4 && k <= 6) begin
                chk("hold_err", int'($signed(err_out)), 1);
                chk("hold_valid", int'(err_valid), 1);
                chk("hold_ovr", int'(overrun), 1);
            end
            if (k == 7) chk("resume_err", int'($signed(err_out)), 5);
        end
        en = 1'b0;
        repeat (3) step();

        // lock: 16 in-tolerance results then one +4
        do_reset();
        err_ready = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            if (k == 17) begin up_therm = therm(4); dwn_therm = '0; end
            else if (k % 2) begin up_therm = therm(1); dwn_therm = '0; end
            else begin up_therm = '0; dwn_therm = therm(1); end
            step();
        end
        en = 1'b0;
        step();
        chk("lock_e18", int'(locked), 0);
        step();
        chk("lock_e19", int'(locked), 1);
        step();
        chk("lock_e20", int'(locked), 0);
        step();

        // reset with a held result and a decoded one behind it
        do_reset();
        err_ready = 1'b1;
        up_therm = 32'h0000_00F7; dwn_therm = '0; en = 1'b1;
        repeat (3) step();
        err_ready = 1'b0;
        up_therm = therm(3);
        repeat (2) step();
        chk("pre_rst_bub", int'(bubble_err), 1);
        chk("pre_rst_ovr", int'(overrun), 1);
        reset_trig = 1'b1;
        #1;
        chk("arst_err", int'(err_out), 0);
        chk("arst_valid", int'(err_valid), 0);
        chk("arst_flags", int'({sat_up, sat_dn, bubble_err, overrun, locked}), 0);
        #1;
        reset_trig = 1'b0;
        model_reset();
        en = 1'b0; err_ready = 1'b1;
        step();
        step();
        chk("post_rst_idle", int'(err_valid), 0);
        up_therm = therm(3); dwn_therm = therm(2); en = 1'b1;
        step();
        en = 1'b0;
        step();
        chk("post_rst_e1", int'(err_valid), 0);
        step();
        chk("post_rst_e2", int'(err_valid), 1);
        chk("post_rst_err", int'($signed(err_out)), 1);
        step();

        // random traffic; the second half keeps codes close to favour lock
        do_reset();
        for (int c = 0; c < 800; c++) begin
            int sel;
            int b;
            en = ($urandom_range(0, 9) < 8);
            err_ready = ($urandom_range(0, 9) < 7);
            sel = (c < 400) ? int'($urandom_range(0, 3)) : 3;
            b = int'($urandom_range(2, 30));
            case (sel)
                0: begin up_therm = $urandom; dwn_therm = $urandom; end
                1: begin up_therm = therm(int'($urandom_range(0, 32)));
                         dwn_therm = therm(int'($urandom_range(0, 32))); end
                default: begin up_therm = therm(b + int'($urandom_range(0, 2)) - 1);
                               dwn_therm = therm(b); end
            endcase
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
